// File: rtl/multi_dataflow_stream_kernel_bridge_pkg.sv
// Shared types and constants for the multi_dataflow engine / kernel bridge.
// Control and flag bundles exchanged with multi_dataflow_engine, plus the bridge FSM encoding.
package multi_dataflow_package;

    localparam int DIM_WIDTH              = 16;
    localparam int DEFAULT_OUT_FIFO_DEPTH = 2;

    typedef struct packed {
        logic                 start;
        logic                 clear;
        logic [DIM_WIDTH-1:0] width;
        logic [DIM_WIDTH-1:0] height;
    } ctrl_bridge_t;

    typedef struct packed {
        logic done;
        logic ready;
        logic idle;
        logic err;
    } flags_bridge_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } bridge_state_t;

endpackage

// File: rtl/multi_dataflow_bridge_fifo.sv
// Output buffer between the kernel's ap_fifo write port and the source stream.
// The head entry is read straight from storage, so popped data is valid in the same cycle.
module multi_dataflow_bridge_fifo import multi_dataflow_package::*; #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = DEFAULT_OUT_FIFO_DEPTH
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  test_mode_i,
    input  logic                  clear_i,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  pop_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  full_o,
    output logic                  empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
    logic [AW:0]           cnt_q;
    logic                  do_push, do_pop;
    logic                  unused_test_mode;

    assign unused_test_mode = test_mode_i;

    assign full_o  = (cnt_q == CNT_FULL);
    assign empty_o = (cnt_q == '0);
    // A full FIFO refuses a push even when a pop frees a slot in the same cycle.
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    assign data_o  = mem_q[rd_ptr_q];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (clear_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= wr_ptr_q + PTR_ONE;
            end
            if (do_pop) rd_ptr_q <= rd_ptr_q + PTR_ONE;
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + CNT_ONE;
                2'b01:   cnt_q <= cnt_q - CNT_ONE;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/multi_dataflow_stream_kernel_bridge.sv
// Adapts HWPE sink/source streams to an HLS kernel's ap_ctrl_hs and ap_fifo ports,
// bounding each frame to width*height beats in both directions.
module multi_dataflow_stream_kernel_bridge #(
    parameter int DATA_WIDTH     = 32,
    parameter int DIM_WIDTH      = 16,
    parameter int OUT_FIFO_DEPTH = 2
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    test_mode_i,
    input  logic                    clear_i,
    input  logic                    start_i,
    input  logic [DIM_WIDTH-1:0]    width_i,
    input  logic [DIM_WIDTH-1:0]    height_i,
    output logic                    done_o,
    output logic                    ready_o,
    output logic                    idle_o,
    output logic                    err_o,
    input  logic                    in_valid_i,
    output logic                    in_ready_o,
    input  logic [DATA_WIDTH-1:0]   in_data_i,
    input  logic [DATA_WIDTH/8-1:0] in_strb_i,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output logic [DATA_WIDTH-1:0]   out_data_o,
    output logic [DATA_WIDTH/8-1:0] out_strb_o,
    output logic                    ap_start_o,
    input  logic                    ap_ready_i,
    input  logic                    ap_done_i,
    input  logic                    ap_idle_i,
    output logic [DATA_WIDTH-1:0]   k_in_dout_o,
    output logic                    k_in_empty_n_o,
    input  logic                    k_in_read_i,
    input  logic [DATA_WIDTH-1:0]   k_out_din_i,
    output logic                    k_out_full_n_o,
    input  logic                    k_out_write_i
);

    import multi_dataflow_package::*;

    localparam int CW = 2 * DIM_WIDTH;
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    // Streams: a beat transfers when valid and ready are both high in the same cycle;
    // valid never waits on ready, and ready may depend combinationally on valid.

    bridge_state_t state_q, state_d;
    flags_bridge_t flags;
    logic [CW-1:0] frame_n, n_q;
    logic [CW-1:0] in_cnt_q, push_cnt_q, out_cnt_q;
    logic          ap_start_q, ap_start_d;
    logic          err_q, err_d;
    logic          start_acc, in_open, push_open;
    logic          in_fire, push, pop;
    logic          fifo_full, fifo_empty;
    logic          unused_inputs;

    assign unused_inputs = ^{in_strb_i, ap_idle_i};

    assign frame_n   = CW'(width_i) * CW'(height_i);
    assign start_acc = (state_q == IDLE) & start_i & ~clear_i;
    assign in_open   = (state_q == RUN) & (in_cnt_q < n_q);
    assign push_open = (state_q == RUN) & (push_cnt_q < n_q);

    assign k_in_dout_o    = in_data_i;
    assign k_in_empty_n_o = in_valid_i & in_open;
    assign in_ready_o     = k_in_read_i & in_open;
    assign in_fire        = in_valid_i & in_ready_o;

    assign k_out_full_n_o = ~fifo_full & push_open;
    assign push           = k_out_write_i & k_out_full_n_o;
    assign out_valid_o    = ~fifo_empty;
    assign pop            = out_valid_o & out_ready_i;
    assign out_strb_o     = '1;

    multi_dataflow_bridge_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (OUT_FIFO_DEPTH)
    ) i_out_fifo (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .test_mode_i (test_mode_i),
        .clear_i     (clear_i),
        .push_i      (push),
        .data_i      (k_out_din_i),
        .pop_i       (pop),
        .data_o      (out_data_o),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    always_comb begin
        state_d    = state_q;
        ap_start_d = ap_start_q;
        err_d      = err_q;
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    if (frame_n == '0) begin
                        state_d = DONE;
                    end else begin
                        state_d    = RUN;
                        ap_start_d = 1'b1;
                        err_d      = 1'b0;
                    end
                end
            end
            RUN: begin
                if (ap_ready_i) ap_start_d = 1'b0;
                if (ap_done_i) begin
                    state_d    = FLUSH;
                    ap_start_d = 1'b0;
                end
            end
            FLUSH: begin
                // out_cnt is final once the buffer has drained.
                if (fifo_empty) begin
                    state_d = DONE;
                    if (out_cnt_q != n_q) err_d = 1'b1;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            n_q        <= '0;
            in_cnt_q   <= '0;
            push_cnt_q <= '0;
            out_cnt_q  <= '0;
            ap_start_q <= 1'b0;
            err_q      <= 1'b0;
        end else if (clear_i) begin
            state_q    <= IDLE;
            in_cnt_q   <= '0;
            push_cnt_q <= '0;
            out_cnt_q  <= '0;
            ap_start_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            ap_start_q <= ap_start_d;
            err_q      <= err_d;
            if (start_acc) begin
                n_q        <= frame_n;
                in_cnt_q   <= '0;
                push_cnt_q <= '0;
                out_cnt_q  <= '0;
            end else begin
                if (in_fire && in_cnt_q < n_q)    in_cnt_q   <= in_cnt_q + CNT_ONE;
                if (push && push_cnt_q < n_q)     push_cnt_q <= push_cnt_q + CNT_ONE;
                if (pop && out_cnt_q < n_q)       out_cnt_q  <= out_cnt_q + CNT_ONE;
            end
        end
    end

    always_comb begin
        flags       = '0;
        flags.done  = (state_q == DONE);
        flags.idle  = (state_q == IDLE);
        flags.ready = (state_q == IDLE);
        flags.err   = err_q;
    end

    assign done_o     = flags.done;
    assign ready_o    = flags.ready;
    assign idle_o     = flags.idle;
    assign err_o      = flags.err;
    assign ap_start_o = ap_start_q;

endmodule
